// File: rtl/bp_lce_req_arb_if.sv
// Bundle of the LCE request arbiter's requester-side and network-side signals.
// The arbiter takes the slave modport; the requesters/network take master.
interface bp_lce_req_arb_if #(
  parameter int num_req_p   = 2,
  parameter int msg_width_p = 512
);
  logic [num_req_p*msg_width_p-1:0] req_i;
  logic [num_req_p-1:0]             req_v_i;
  logic [num_req_p-1:0]             req_yumi_o;
  logic [num_req_p-1:0]             req_done_i;
  logic [num_req_p-1:0]             credits_full_o;
  logic [num_req_p-1:0]             credits_empty_o;
  logic [msg_width_p-1:0]           lce_req_o;
  logic                             lce_req_v_o;
  logic                             lce_req_ready_i;
  logic                             idle_o;

  modport slave (
    input  req_i, req_v_i, req_done_i, lce_req_ready_i,
    output req_yumi_o, credits_full_o, credits_empty_o, lce_req_o, lce_req_v_o, idle_o
  );

  modport master (
    output req_i, req_v_i, req_done_i, lce_req_ready_i,
    input  req_yumi_o, credits_full_o, credits_empty_o, lce_req_o, lce_req_v_o, idle_o
  );
endinterface

// File: rtl/bp_lce_req_arb.sv
// Round-robin arbiter sharing one LCE request network port among num_req_p
// requesters, with per-requester credit limits and a 2-entry output FIFO.
module bp_lce_req_arb #(
  parameter int num_req_p   = 2,
  parameter int msg_width_p = 512,
  parameter int credits_p   = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  bp_lce_req_arb_if.slave   bus
);

  localparam int ptr_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w = $clog2(credits_p + 1);

  logic [ptr_w-1:0]       last_r;
  logic [ptr_w-1:0]       grant_idx;
  logic [ptr_w-1:0]       cand;
  logic                   grant;
  logic [num_req_p-1:0]   yumi;
  logic [num_req_p-1:0]   full;
  logic [num_req_p-1:0]   empty;
  logic [num_req_p-1:0]   eligible;
  logic [cnt_w-1:0]       cnt [num_req_p];

  logic [msg_width_p-1:0] mem [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             count;
  logic                   deq;
  logic                   space;
  logic [msg_width_p-1:0] enq_data;

  // A full FIFO still accepts when its head leaves in the same cycle.
  assign deq   = (count != 2'd0) & bus.lce_req_ready_i;
  assign space = (count != 2'd2) | deq;

  always_comb begin
    for (int unsigned i = 0; i < num_req_p; i++) begin
      full[i]  = (cnt[i] == cnt_w'(credits_p));
      empty[i] = (cnt[i] == '0);
    end
  end

  assign eligible = bus.req_v_i & ~full & {num_req_p{space}};

  always_comb begin
    grant     = 1'b0;
    grant_idx = last_r;
    cand      = last_r;
    for (int unsigned k = 1; k <= num_req_p; k++) begin
      cand = ptr_w'((32'(last_r) + k) % num_req_p);
      if (!grant && eligible[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign yumi     = grant ? (num_req_p'(1) << grant_idx) : '0;
  assign enq_data = bus.req_i[grant_idx*msg_width_p +: msg_width_p];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_r <= ptr_w'(num_req_p - 1);
    end else if (grant) begin
      last_r <= grant_idx;
    end
  end

  // Grant and completion in the same cycle cancel; completions at zero are dropped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < num_req_p; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (yumi[i] && !bus.req_done_i[i]) begin
          cnt[i] <= cnt[i] + cnt_w'(1);
        end else if (!yumi[i] && bus.req_done_i[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - cnt_w'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (grant) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      case ({grant, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.req_yumi_o      = yumi;
  assign bus.credits_full_o  = full;
  assign bus.credits_empty_o = empty;
  assign bus.lce_req_o       = mem[rd_ptr];
  assign bus.lce_req_v_o     = (count != 2'd0);
  assign bus.idle_o          = (count == 2'd0) & (&empty);

endmodule

// File: doc/bp_lce_req_arb.md
# bp_lce_req_arb

Round-robin arbiter that shares one outbound LCE request network port among `num_req_p` LCE request handlers (e.g. I$ and D$ LCEs in a tile).
- Accepts single-beat `lce_req` messages with a valid->yumi handshake.
- Enforces a per-requester outstanding-request credit limit.
- Buffers granted messages in a 2-entry output FIFO that drives the network with ready/valid.
- Sits between the per-cache LCE request handlers and the coherence network injection port.

## Interface
Parameters:
- `num_req_p`, 2, number of requesting LCEs (>=2)
- `msg_width_p`, 512, width of one LCE request message (`lce_req_msg_width_lp`)
- `credits_p`, 8, max outstanding requests per requester (>=1); counter width `$clog2(credits_p+1)`

Ports:
- `clk_i`  in  1  single clock
- `reset_i`  in  1  asynchronous, active-high reset
- `req_i`  in  `num_req_p*msg_width_p`  request messages; slice i belongs to requester i
- `req_v_i`  in  `num_req_p`  request valid; must not depend on `req_yumi_o`
- `req_yumi_o`  out  `num_req_p`  one-hot or zero; message i consumed this cycle
- `req_done_i`  in  `num_req_p`  single-cycle pulse, one request of requester i completed
- `credits_full_o`  out  `num_req_p`  requester i count == `credits_p`
- `credits_empty_o`  out  `num_req_p`  requester i count == 0
- `lce_req_o`  out  `msg_width_p`  head of output FIFO
- `lce_req_v_o`  out  1  output FIFO non-empty
- `lce_req_ready_i`  in  1  network accepts when `lce_req_v_o & lce_req_ready_i`
- `idle_o`  out  1  FIFO empty and all credit counters 0

## Operation
- **Eligibility.** Requester i is eligible when all of the following hold:
  - `req_v_i[i]`
  - `~credits_full_o[i]`
  - the output FIFO is not full. The FIFO counts as not full when it holds fewer than 2 entries, or when it holds 2 entries and a dequeue (`v & ready`) happens in the same cycle.
- **Arbitration.**
  - A round-robin pointer `last_r` holds the index of the last granted requester.
  - Priority order is `last_r+1, last_r+2, ...`, wrapping modulo `num_req_p`.
  - The first eligible requester in that order is granted: its `req_yumi_o` bit is asserted and its `req_i` slice is enqueued into the FIFO.
  - At most one grant per cycle.
  - `last_r` updates to the granted index only on a grant; otherwise it holds.
- **Credits.**
  - The counter for requester i increments on `req_yumi_o[i]` and decrements on `req_done_i[i]`.
  - If both occur in the same cycle, the counter is unchanged.
  - A `req_done_i[i]` while the count is 0 is ignored: the counter stays at 0.
  - The counter never exceeds `credits_p`, because no grant is issued while full.
- **Output FIFO.**
  - 2 entries, in-order.
  - Enqueue and dequeue may occur in the same cycle at any occupancy, including full.
  - The message data is never modified.
- **Reset.**
  - Asynchronous assertion clears the FIFO; any in-flight messages are discarded.
  - All credit counters go to 0.
  - `last_r` is set to `num_req_p-1`, so requester 0 has top priority first.
  - Reset asserted mid-operation has the same effect, with no partial state retained.

## Timing
- **Reset values:**
  - `req_yumi_o=0`
  - `lce_req_v_o=0`
  - `lce_req_o=0`
  - `credits_full_o=0`
  - `credits_empty_o` all 1
  - `idle_o=1`
- **Grant path.** `req_yumi_o` is combinational from `req_v_i`, the credit counters, the FIFO state, `last_r` and `lce_req_ready_i`.
- **Latency.** A message granted in cycle N is presented on `lce_req_o` with `lce_req_v_o=1` in cycle N+1 at the earliest. It is later only if older entries are still queued.
- **Throughput.** One message per cycle is sustained while `lce_req_ready_i` stays high.
- **Output holding.** `lce_req_v_o` and `lce_req_o` depend only on registered state. They hold stable while `lce_req_ready_i` is low.
- **Credit status.** `credits_full_o`, `credits_empty_o` and `idle_o` are decoded from registered counters, so they reflect events of cycle N starting in cycle N+1.

## Test plan
1. **Reset:** assert `reset_i` asynchronously mid-cycle with 2 messages queued and counts {3,1} -> immediately `lce_req_v_o=0`, counts {0,0}, `idle_o=1`; after release, the first simultaneous request pair grants requester 0.
2. **Round-robin fairness:** `req_v_i=2'b11` held, `lce_req_ready_i=1`, `credits_p=8` -> grants alternate 0,1,0,1. Output order equals grant order, each message 1 cycle after its yumi, 1 per cycle.
3. **Credit limit:** only requester 1 valid, `req_done_i=0` -> exactly 8 yumis, then `credits_full_o[1]=1` and no yumi. Pulse `req_done_i[1]` once -> next cycle `credits_full_o[1]=0` and exactly one more yumi.
4. **Backpressure:** `lce_req_ready_i=0` with both requesters valid -> 2 grants, then none. Raising ready for 1 cycle -> head dequeued and one new grant in the same cycle, occupancy stays 2.
5. **Simultaneous events:**
   - `req_yumi_o[0]` and `req_done_i[0]` in the same cycle at count 5 -> count stays 5.
   - `req_done_i[1]` at count 0 -> count stays 0 and `credits_empty_o[1]` stays 1.
6. **Idle:** after all messages drain and all done pulses have been returned -> `idle_o=1` one cycle after the last done pulse.
